// File: rtl/bcd_countdown_timer_if.sv
// Control/status bundle between the keypad capture logic and the BCD countdown timer.
// master = controlling side (keypad/game FSM), slave = the timer itself.
interface bcd_countdown_timer_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    localparam int unsigned W = 4 * NUM_DIGITS;

    logic         load;
    logic [W-1:0] load_value;
    logic         start;
    logic         pause;
    logic         tick;
    logic [W-1:0] count;
    logic         running;
    logic         paused;
    logic         warn;
    logic         expired;
    logic         expire_pulse;

    modport master (
        output load, load_value, start, pause, tick,
        input  count, running, paused, warn, expired, expire_pulse
    );

    modport slave (
        input  load, load_value, start, pause, tick,
        output count, running, paused, warn, expired, expire_pulse
    );
endinterface

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer with load/start/pause control, a low-time
// warning flag and expiry indication. All status outputs come straight from flops.
module bcd_countdown_timer #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter logic [31:0] WARN_THRESHOLD = 32'h0000_0010
) (
    input  logic                  clk,
    input  logic                  rst,
    bcd_countdown_timer_if.slave  bus
);
    localparam int unsigned W = 4 * NUM_DIGITS;
    localparam logic [W-1:0] THRESH = W'(WARN_THRESHOLD);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOADED = 3'd1,
        S_RUN    = 3'd2,
        S_PAUSE  = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    state_e       state_q;
    logic [W-1:0] count_q;
    logic         running_q;
    logic         paused_q;
    logic         warn_q;
    logic         expired_q;
    logic         expire_pulse_q;

    logic [W-1:0] count_dec_d;
    logic [W-1:0] load_clamped_d;
    logic         count_zero_c;
    logic         dec_zero_c;
    logic         count_warn_c;
    logic         dec_warn_c;

    // BCD decrement: zero digits wrap to 9 and pass the borrow upward
    always_comb begin
        logic borrow;
        count_dec_d = count_q;
        borrow      = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (borrow) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    count_dec_d[4*i +: 4] = 4'd9;
                end else begin
                    count_dec_d[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    borrow                = 1'b0;
                end
            end
        end
    end

    // Saturate each loaded nibble to a legal BCD digit
    always_comb begin
        load_clamped_d = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            load_clamped_d[4*i +: 4] = (bus.load_value[4*i +: 4] > 4'd9) ? 4'd9
                                                                        : bus.load_value[4*i +: 4];
        end
    end

    // With valid BCD nibbles, an unsigned vector compare is a digit-wise MSD-first compare
    always_comb begin
        count_zero_c = (count_q == '0);
        dec_zero_c   = (count_dec_d == '0);
        count_warn_c = (count_q <= THRESH);
        dec_warn_c   = (count_dec_d <= THRESH);
    end

    // Control FSM; priority is rst > load > pause > start > tick
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            count_q        <= '0;
            running_q      <= 1'b0;
            paused_q       <= 1'b0;
            warn_q         <= 1'b0;
            expired_q      <= 1'b0;
            expire_pulse_q <= 1'b0;
        end else if (bus.load) begin
            state_q        <= S_LOADED;
            count_q        <= load_clamped_d;
            running_q      <= 1'b0;
            paused_q       <= 1'b0;
            warn_q         <= 1'b0;
            expired_q      <= 1'b0;
            expire_pulse_q <= 1'b0;
        end else begin
            expire_pulse_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                end
                S_LOADED: begin
                    if (bus.start) begin
                        if (count_zero_c) begin
                            state_q        <= S_DONE;
                            expired_q      <= 1'b1;
                            expire_pulse_q <= 1'b1;
                        end else begin
                            state_q   <= S_RUN;
                            running_q <= 1'b1;
                            warn_q    <= count_warn_c;
                        end
                    end
                end
                S_RUN: begin
                    if (bus.pause) begin
                        state_q   <= S_PAUSE;
                        running_q <= 1'b0;
                        paused_q  <= 1'b1;
                    end else if (bus.tick && !count_zero_c) begin
                        count_q <= count_dec_d;
                        if (dec_zero_c) begin
                            state_q        <= S_DONE;
                            running_q      <= 1'b0;
                            warn_q         <= 1'b0;
                            expired_q      <= 1'b1;
                            expire_pulse_q <= 1'b1;
                        end else begin
                            warn_q <= dec_warn_c;
                        end
                    end
                end
                S_PAUSE: begin
                    // Simultaneous start and pause keeps the timer frozen
                    if (bus.start && !bus.pause) begin
                        state_q   <= S_RUN;
                        running_q <= 1'b1;
                        paused_q  <= 1'b0;
                    end
                end
                S_DONE: begin
                end
                default: begin
                    state_q   <= S_IDLE;
                    count_q   <= '0;
                    running_q <= 1'b0;
                    paused_q  <= 1'b0;
                    warn_q    <= 1'b0;
                    expired_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.count        = count_q;
    assign bus.running      = running_q;
    assign bus.paused       = paused_q;
    assign bus.warn         = warn_q;
    assign bus.expired      = expired_q;
    assign bus.expire_pulse = expire_pulse_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer: directed scenarios plus random
// stimulus, all checked against a decimal-integer model of the timer.
module tb_bcd_countdown_timer;
    localparam int unsigned ND  = 4;
    localparam int unsigned W   = 4 * ND;
    localparam int          THR = 10;          // 16'h0010 read as a decimal count

    localparam int M_IDLE = 0, M_LOADED = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    bcd_countdown_timer_if #(.NUM_DIGITS(ND)) bus ();

    bcd_countdown_timer #(
        .NUM_DIGITS    (ND),
        .WARN_THRESHOLD(32'h0000_0010)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int m_state = M_IDLE;
    int m_val   = 0;
    bit m_pulse = 1'b0;
    int checks  = 0;
    int passes  = 0;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < int'(ND); i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int clamp_to_int(input logic [W-1:0] lv);
        int v, mul, d;
        v   = 0;
        mul = 1;
        for (int i = 0; i < int'(ND); i++) begin
            d = int'(lv[4*i +: 4]);
            if (d > 9) d = 9;
            v   = v + d * mul;
            mul = mul * 10;
        end
        return v;
    endfunction

    // {count, running, paused, warn, expired, expire_pulse}
    function automatic logic [W+4:0] exp_vec();
        logic w;
        w = ((m_state == M_RUN) || (m_state == M_PAUSE)) && (m_val <= THR);
        return {to_bcd(m_val), 1'(m_state == M_RUN), 1'(m_state == M_PAUSE), w,
                1'(m_state == M_DONE), m_pulse};
    endfunction

    function automatic logic [W+4:0] obs_vec();
        return {bus.count, bus.running, bus.paused, bus.warn, bus.expired, bus.expire_pulse};
    endfunction

    task automatic model_update(input bit r, input bit ld, input logic [W-1:0] lv,
                                input bit st, input bit ps, input bit tk);
        m_pulse = 1'b0;
        if (!r) begin
            m_state = M_IDLE;
            m_val   = 0;
        end else if (ld) begin
            m_state = M_LOADED;
            m_val   = clamp_to_int(lv);
        end else begin
            case (m_state)
                M_LOADED: if (st) begin
                    if (m_val == 0) begin m_state = M_DONE; m_pulse = 1'b1; end
                    else m_state = M_RUN;
                end
                M_RUN: begin
                    if (ps) m_state = M_PAUSE;
                    else if (tk && m_val > 0) begin
                        m_val = m_val - 1;
                        if (m_val == 0) begin m_state = M_DONE; m_pulse = 1'b1; end
                    end
                end
                M_PAUSE: if (st && !ps) m_state = M_RUN;
                default: ;
            endcase
        end
    endtask

    // Drive one cycle of inputs, advance the model, sample #1 after the edge
    task automatic step(input bit r, input bit ld, input logic [W-1:0] lv,
                        input bit st, input bit ps, input bit tk);
        rst            = r;
        bus.load       = ld;
        bus.load_value = lv;
        bus.start      = st;
        bus.pause      = ps;
        bus.tick       = tk;
        model_update(r, ld, lv, st, ps, tk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 16'h1234, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 16'h1234, 1'b1, 1'b0, 1'b1);
        checks++;
        if (obs_vec() !== {16'h0000, 5'b00000})
            $display("FAIL reset_hold: got %h want %h", obs_vec(), {16'h0000, 5'b00000});
        else passes++;
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs_vec() !== exp_vec())
            $display("FAIL reset_idle_ignores: got %h want %h", obs_vec(), exp_vec());
        else passes++;
    endtask

    task automatic test_load_clamp();
        step(1'b1, 1'b1, 16'h1A00, 1'b1, 1'b1, 1'b1);
        checks++;
        if (obs_vec() !== {16'h1900, 5'b00000})
            $display("FAIL load_clamp: got %h want %h", obs_vec(), {16'h1900, 5'b00000});
        else passes++;
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs_vec() !== {16'h1899, 5'b10000})
            $display("FAIL borrow_1900: got %h want %h", obs_vec(), {16'h1899, 5'b10000});
        else passes++;
        step(1'b1, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs_vec() !== exp_vec() || bus.count !== 16'h0999)
            $display("FAIL borrow_1000: got %h want %h", obs_vec(), exp_vec());
        else passes++;
    endtask

    task automatic test_expiry();
        step(1'b1, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec())
                $display("FAIL expiry_tick%0d: got %h want %h", i, obs_vec(), exp_vec());
            else passes++;
        end
    endtask

    task automatic test_pause();
        step(1'b1, 1'b1, 16'h0051, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs_vec() !== {16'h0050, 5'b01000})
            $display("FAIL pause_frozen: got %h want %h", obs_vec(), {16'h0050, 5'b01000});
        else passes++;
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        checks++;
        if (obs_vec() !== exp_vec())
            $display("FAIL pause_wins: got %h want %h", obs_vec(), exp_vec());
        else passes++;
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs_vec() !== {16'h0049, 5'b10000})
            $display("FAIL resume_tick: got %h want %h", obs_vec(), {16'h0049, 5'b10000});
        else passes++;
    endtask

    task automatic test_warn();
        step(1'b1, 1'b1, 16'h0012, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        checks++;
        if (obs_vec() !== exp_vec())
            $display("FAIL warn_start: got %h want %h", obs_vec(), exp_vec());
        else passes++;
        for (int i = 0; i < 13; i++) begin
            step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec())
                $display("FAIL warn_tick%0d: got %h want %h", i, obs_vec(), exp_vec());
            else passes++;
        end
    endtask

    task automatic test_overrides();
        step(1'b1, 1'b1, 16'h0203, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h0500, 1'b1, 1'b1, 1'b1);
        checks++;
        if (obs_vec() !== {16'h0500, 5'b00000})
            $display("FAIL load_over_run: got %h want %h", obs_vec(), {16'h0500, 5'b00000});
        else passes++;
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 16'h0777, 1'b1, 1'b0, 1'b1);
        checks++;
        if (obs_vec() !== {16'h0000, 5'b00000})
            $display("FAIL rst_over_run: got %h want %h", obs_vec(), {16'h0000, 5'b00000});
        else passes++;
        step(1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        checks++;
        if (obs_vec() !== {16'h0000, 5'b00011})
            $display("FAIL load_zero_start: got %h want %h", obs_vec(), {16'h0000, 5'b00011});
        else passes++;
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        checks++;
        if (obs_vec() !== {16'h0000, 5'b00010})
            $display("FAIL done_hold: got %h want %h", obs_vec(), {16'h0000, 5'b00010});
        else passes++;
    endtask

    task automatic test_random();
        logic [W-1:0] lv;
        bit r, ld, st, ps, tk;
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 79) != 0);
            ld = ($urandom_range(0, 24) == 0);
            st = ($urandom_range(0, 3) == 0);
            ps = ($urandom_range(0, 9) == 0);
            tk = ($urandom_range(0, 1) == 0);
            lv = W'($urandom);
            if ($urandom_range(0, 1) == 0) lv[W-1:8] = '0;
            step(r, ld, lv, st, ps, tk);
            checks++;
            if (obs_vec() !== exp_vec())
                $display("FAIL random_cycle%0d: got %h want %h", i, obs_vec(), exp_vec());
            else passes++;
        end
    endtask

    initial begin
        bus.load       = 1'b0;
        bus.load_value = '0;
        bus.start      = 1'b0;
        bus.pause      = 1'b0;
        bus.tick       = 1'b0;
        test_reset();
        test_load_clamp();
        test_expiry();
        test_pause();
        test_warn();
        test_overrides();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Parametrised multi-digit BCD countdown timer. Generalises the single-digit borrow-chain timer into one block.
- Loads a user BCD value and counts down on an external tick enable.
- Supports start, pause and resume; flags a low-time warning and expiry.
- Sits between the user keypad/switch capture logic and the seven-segment display and game-control FSM.

Parameters:
- NUM_DIGITS, 4, number of BCD digits; legal range 1..8. Digit 0 is least significant, at bits [3:0].
- WARN_THRESHOLD, 16'h0010, BCD-coded count at or below which warn asserts. Width is 4*NUM_DIGITS; upper digits are zero-extended.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-low reset
- load  input  1  single-cycle pulse; captures load_value
- load_value  input  4*NUM_DIGITS  user BCD digits, one nibble per digit
- start  input  1  level/pulse; begins or resumes the countdown
- pause  input  1  level/pulse; freezes the countdown
- tick  input  1  one-clk-wide decrement enable (e.g. 1 Hz strobe)
- count  output  4*NUM_DIGITS  current BCD count, registered
- running  output  1  high in RUN state
- paused  output  1  high in PAUSE state
- warn  output  1  count <= WARN_THRESHOLD while in RUN or PAUSE
- expired  output  1  high in DONE state
- expire_pulse  output  1  one-cycle strobe on entry to DONE

Behaviour:
- All outputs are registered and update on the rising edge of clk.
- Reset (rst==0 at a clk edge):
  - state=IDLE, count=0, running=0, paused=0, warn=0, expired=0, expire_pulse=0.
  - Reset overrides every other input, including in mid-run.
- States: IDLE, LOADED, RUN, PAUSE, DONE.
- Input priority each cycle: rst > load > pause > start > tick.
- load, in any state:
  - Each nibble is clamped: a value >9 loads as 9; otherwise it loads as-is.
  - state goes to LOADED; expired and warn clear on the same edge.
  - Any tick, start or pause in that cycle is ignored.
- IDLE:
  - start, pause and tick are all ignored.
  - Only load leaves IDLE.
- LOADED:
  - start with count!=0 -> RUN.
  - start with count==0 -> DONE, with expire_pulse=1 for that cycle.
  - tick and pause are ignored.
- RUN:
  - pause -> PAUSE; a tick in the same cycle is discarded.
  - tick with count!=0 -> count decrements by one in BCD on the next edge (one-cycle latency).
  - Borrow chain: a digit at 0 wraps to 9 and borrows from the next higher digit. Example: 0100 -> 0099.
  - If the decrement produces 0, on the same edge count=0, state=DONE, expire_pulse=1.
  - start while already running has no effect.
- PAUSE:
  - count is frozen; tick is ignored.
  - start without pause -> RUN.
  - start and pause together -> stays in PAUSE (pause wins).
- DONE:
  - count holds 0 and expired=1 until load or reset.
  - start, pause and tick are ignored.
  - expire_pulse is high only in the entry cycle.
- warn compares count against WARN_THRESHOLD as a BCD value, most significant digit first. It is 0 in IDLE, LOADED and DONE.
- count never goes below 0 and never holds a non-BCD nibble.

Test Plan:
- Reset then idle: hold rst=0 for 2 cycles, then pulse start and tick -> count=0000, state IDLE, all flags 0.
- Load clamp and borrow chain:
  - NUM_DIGITS=4; load 16'h1A00 -> count=1900.
  - start, then 1 tick -> 1899.
  - From a load of 1000, 1 tick -> 0999.
- Expiry:
  - load 0003, start, 3 ticks -> count 0002, 0001, 0000.
  - expire_pulse high exactly one cycle on the 0000 edge; expired stays 1.
  - Further ticks leave count at 0000.
- Pause/resume:
  - While running at 0050, pause then 5 ticks -> count stays 0050, paused=1.
  - start and pause together -> still paused.
  - start alone, then 1 tick -> 0049.
- Warn threshold: WARN_THRESHOLD=0010, load 0012, run -> warn=0 at 0012 and 0011; warn=1 from 0010 through 0001; warn=0 in DONE.
- Mid-operation overrides:
  - load 0500 while running at 0203 with tick high in the same cycle -> count=0500, LOADED, tick ignored.
  - rst=0 while running -> count=0000, IDLE next edge.
  - load 0000 then start -> DONE and expire_pulse on the next edge.
